// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped branch target buffer with a 2-bit saturating confidence
//   counter per entry. The fetch stage looks up pcF combinationally. The
//   execute stage trains the table with resolved control transfers.
//
// Ports
//   clk              : clock, all state changes on posedge
//   rst              : synchronous active-high reset (clears table and counter)
//   pcF              : fetch PC to look up
//   bPredictedTakenF : entry hit with counter in a taken state
//   predTargetF      : predicted target, 0 when not predicted taken
//   pcE              : PC of the resolving control-transfer instruction
//   btbTargetE       : resolved pc+imm target
//   btbUpdateE       : resolved taken non-JALR branch or JAL (allocate/train)
//   pcSelE           : resolved taken (any taken branch or jump)
//   wrongBranchE     : prediction mismatch in execute
//   mispredictCount  : number of cycles with wrongBranchE asserted (wraps)
// -----------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int IDXW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        bPredictedTakenF,
    output logic [31:0] predTargetF,
    input  logic [31:0] pcE,
    input  logic [31:0] btbTargetE,
    input  logic        btbUpdateE,
    input  logic        pcSelE,
    input  logic        wrongBranchE,
    output logic [31:0] mispredictCount
);

    localparam int TAGW = 30 - IDXW;

    logic              r_valid  [ENTRIES];
    logic [TAGW-1:0]   r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [31:0]       r_miss_cnt;

    logic [IDXW-1:0]   w_idx_f;
    logic [TAGW-1:0]   w_tag_f;
    logic              w_hit_f;
    logic [IDXW-1:0]   w_idx_e;
    logic [TAGW-1:0]   w_tag_e;
    logic              w_hit_e;
    logic              w_unused_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Instructions are word aligned, so the low two PC bits carry no information.
    assign w_unused_bits = ^{pcF[1:0], pcE[1:0]};

    assign w_idx_f = pcF[IDXW+1:2];
    assign w_tag_f = pcF[31:IDXW+2];
    assign w_idx_e = pcE[IDXW+1:2];
    assign w_tag_e = pcE[31:IDXW+2];

    // Lookups read registered contents only; an update in the same cycle
    // becomes visible after the edge, never through a bypass.
    assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

    assign bPredictedTakenF = w_hit_f && r_ctr[w_idx_f][1];
    assign predTargetF      = bPredictedTakenF ? r_target[w_idx_f] : 32'h0;
    assign mispredictCount  = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= 2'b00;
            end
            r_miss_cnt <= 32'h0;
        end else begin
            // Only the entry at pcE's index is ever written, so one write per cycle.
            if (btbUpdateE) begin
                if (w_hit_e) begin
                    r_target[w_idx_e] <= btbTargetE;
                    r_ctr[w_idx_e]    <= sat_inc(r_ctr[w_idx_e]);
                end else begin
                    // Allocation evicts whatever alias currently owns the slot.
                    r_valid[w_idx_e]  <= 1'b1;
                    r_tag[w_idx_e]    <= w_tag_e;
                    r_target[w_idx_e] <= btbTargetE;
                    r_ctr[w_idx_e]    <= 2'b10;
                end
            end else if (!pcSelE && wrongBranchE && w_hit_e) begin
                r_ctr[w_idx_e] <= sat_dec(r_ctr[w_idx_e]);
            end

            if (wrongBranchE) begin
                r_miss_cnt <= r_miss_cnt + 32'h1;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        bPredictedTakenF;
    logic [31:0] predTargetF;
    logic [31:0] pcE;
    logic [31:0] btbTargetE;
    logic        btbUpdateE;
    logic        pcSelE;
    logic        wrongBranchE;
    logic [31:0] mispredictCount;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one record per slot, index/tag derived arithmetically.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    int unsigned m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_cnt;

    branch_target_buffer #(.ENTRIES(ENTRIES), .IDXW(4)) dut (
        .clk(clk), .rst(rst), .pcF(pcF),
        .bPredictedTakenF(bPredictedTakenF), .predTargetF(predTargetF),
        .pcE(pcE), .btbTargetE(btbTargetE), .btbUpdateE(btbUpdateE),
        .pcSelE(pcSelE), .wrongBranchE(wrongBranchE),
        .mispredictCount(mispredictCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_tgt(input logic [31:0] pc);
        return m_taken(pc) ? m_target[slot(pc)] : 32'h0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic m_edge(input bit r, input logic [31:0] pe, input logic [31:0] te,
                          input bit upd, input bit ps, input bit wb);
        int s;
        bit h;
        if (r) begin
            m_reset();
            return;
        end
        s = slot(pe);
        h = m_hit(pe);
        if (upd) begin
            if (!h) begin
                m_valid[s] = 1; m_tag[s] = tagof(pe); m_ctr[s] = 2;
            end else begin
                m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
            end
            m_target[s] = te;
        end else if (!ps && wb && h) begin
            m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
        if (wb) m_cnt = m_cnt + 1;
    endtask

    // One clock: drive at negedge, compare lookup against model, then advance model at the edge.
    task automatic cyc(input bit r, input logic [31:0] pf, input logic [31:0] pe,
                       input logic [31:0] te, input bit upd, input bit ps, input bit wb,
                       input bit docheck);
        @(negedge clk);
        rst = r; pcF = pf; pcE = pe; btbTargetE = te;
        btbUpdateE = upd; pcSelE = ps; wrongBranchE = wb;
        #1;
        if (docheck) begin
            chk("taken", {31'h0, bPredictedTakenF}, {31'h0, m_taken(pf)});
            chk("target", predTargetF, m_tgt(pf));
            chk("count", mispredictCount, m_cnt);
        end
        @(posedge clk);
        m_edge(r, pe, te, upd, ps, wb);
    endtask

    task automatic probe(input string tag, input logic [31:0] pf,
                         input bit exp_taken, input logic [31:0] exp_tgt);
        @(negedge clk);
        rst = 0; pcF = pf; pcE = 32'h0; btbTargetE = 32'h0;
        btbUpdateE = 0; pcSelE = 0; wrongBranchE = 0;
        #1;
        chk({tag, ".taken"}, {31'h0, bPredictedTakenF}, {31'h0, exp_taken});
        chk({tag, ".target"}, predTargetF, exp_tgt);
    endtask

    initial begin
        logic [31:0] pf, pe, te;
        bit upd, ps, wb, r;
        int kind;

        rst = 1; pcF = 0; pcE = 0; btbTargetE = 0;
        btbUpdateE = 0; pcSelE = 0; wrongBranchE = 0;
        m_reset();

        cyc(1, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        probe("rst_lookup", 32'h100, 0, 32'h0);
        chk("rst_count", mispredictCount, 32'h0);

        // Allocate 0x100 -> 0x200, counter starts weakly taken.
        cyc(0, 32'h100, 32'h100, 32'h200, 1, 1, 0, 1);
        probe("alloc", 32'h100, 1, 32'h200);

        // Two not-taken mispredicts: 10 -> 01 -> 00.
        cyc(0, 32'h100, 32'h100, 32'h0, 0, 0, 1, 1);
        probe("dec1", 32'h100, 0, 32'h0);
        cyc(0, 32'h100, 32'h100, 32'h0, 0, 0, 1, 1);
        probe("dec2", 32'h100, 0, 32'h0);
        chk("miss_count2", mispredictCount, 32'h2);
        // From 00 a single taken update lands on 01, still not taken.
        cyc(0, 32'h100, 32'h100, 32'h200, 1, 1, 1, 1);
        probe("floor", 32'h100, 0, 32'h0);
        cyc(0, 32'h100, 32'h100, 32'h200, 1, 1, 0, 1);
        probe("retrain", 32'h100, 1, 32'h200);

        // Alias in slot 0 evicts 0x100.
        cyc(0, 32'h140, 32'h140, 32'h300, 1, 1, 1, 1);
        probe("alias_old", 32'h100, 0, 32'h0);
        probe("alias_new", 32'h140, 1, 32'h300);

        // Same-cycle allocation is not bypassed to fetch.
        cyc(0, 32'h180, 32'h180, 32'h400, 1, 1, 1, 1);
        probe("same_next", 32'h180, 1, 32'h400);
        for (int i = 0; i < 3; i++) cyc(0, 32'h180, 32'h180, 32'h400, 1, 1, 0, 1);
        // Saturated at 11, so one decrement still predicts taken.
        cyc(0, 32'h180, 32'h180, 32'h0, 0, 0, 1, 1);
        probe("sat_hi", 32'h180, 1, 32'h400);

        // Reset wins over a simultaneous allocation.
        cyc(1, 32'h1C0, 32'h1C0, 32'h500, 1, 1, 1, 1);
        probe("rst_upd", 32'h1C0, 0, 32'h0);
        probe("rst_clear", 32'h180, 0, 32'h0);
        chk("rst_count2", mispredictCount, 32'h0);

        // Counter wrap.
        @(negedge clk);
        force dut.r_miss_cnt = 32'hFFFFFFFE;
        #1;
        release dut.r_miss_cnt;
        m_cnt = 32'hFFFFFFFE;
        cyc(0, 32'h0, 32'h40, 32'h0, 0, 0, 1, 1);
        cyc(0, 32'h0, 32'h40, 32'h0, 0, 0, 1, 1);
        probe("wrap", 32'h0, 0, 32'h0);
        chk("wrap_count", mispredictCount, 32'h0);

        // Randomized traffic over a small aliasing PC pool.
        for (int n = 0; n < 500; n++) begin
            pe = (($urandom_range(0, 2) * 32'h1000) + ($urandom_range(0, 23) << 2))
                 | $urandom_range(0, 3);
            pf = ($urandom_range(0, 3) == 0) ? pe
                 : (($urandom_range(0, 2) * 32'h1000) + ($urandom_range(0, 23) << 2));
            te = $urandom & 32'hFFFF_FFFC;
            kind = $urandom_range(0, 3);
            upd = (kind == 1);
            ps  = (kind == 1) || (kind == 2);
            wb  = ps ^ m_taken(pe);
            if (kind == 0) wb = 0;
            r = ($urandom_range(0, 63) == 0);
            cyc(r, pf, pe, te, upd, ps, wb, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
